div8_seq_ctrl: RTL

DIV8_SEQ_CTRL -- requirements
Module: div8_seq_ctrl

---
 rtl/div8_pkg.sv | 14 +
 rtl/bit8_subtractor.sv | 10 +
 rtl/div8_seq_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/div8_pkg.sv
// Shared types and constants for the sequential 8-bit restoring divider.
package div8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned ITERS        = 8;
  localparam int unsigned CNT_W        = $clog2(ITERS);
  localparam logic [7:0]  DBZ_QUOTIENT = 8'hFF;

endpackage

// File: rtl/bit8_subtractor.sv
// Combinational 8-bit subtractor; result wraps modulo 2^8.
module bit8_subtractor (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result
);

  assign result = a - b;

endmodule

// File: rtl/div8_seq_ctrl.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero bypasses the iteration and reports an all-ones quotient.
module div8_seq_ctrl
  import div8_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   trial;
  logic [7:0]       diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             last_iter;

  // Trial value: partial remainder with the next dividend bit appended.
  assign trial = {rem_q, dvd_q[WIDTH-1]};

  // Difference is exact modulo 2^8 whenever trial >= divisor.
  bit8_subtractor u_sub (
    .a      (8'(trial)),
    .b      (8'(dsr_q)),
    .result (diff)
  );

  assign ge        = trial >= {1'b0, dsr_q};
  assign rem_step  = ge ? WIDTH'(diff) : trial[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], ge};
  assign last_iter = cnt_q == CNT_W'(ITERS - 1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q       <= dividend;
            dsr_q       <= divisor;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            div_by_zero <= divisor == '0;
            if (divisor == '0) begin
              quotient  <= WIDTH'(DBZ_QUOTIENT);
              remainder <= dividend;
            end
          end
        end
        CALC: begin
          dvd_q <= dvd_q << 1;
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            quotient  <= quo_step;
            remainder <= rem_step;
          end
        end
        default: ;
      endcase
      busy <= state_d != IDLE;
      done <= state_d == DONE;
    end
  end

endmodule
